// File: rtl/lock_cfg_pkg.sv
// Shared types and constants for the lockable-register configuration sequencer
// and its register bank.
package lock_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    LOCK,
    PROBE,
    CHECK,
    DONE,
    ERROR
  } lock_seq_state_t;

  localparam int DATA_W_DEF = 16;

  localparam logic ERR_VERIFY = 1'b0;
  localparam logic ERR_PROBE  = 1'b1;

endpackage

// File: rtl/locked_reg_bank.sv
// Bank of lockable registers: writes land until the shared Lock is seen,
// after which contents are frozen until reset. Read port is a plain mux.
module locked_reg_bank
  import lock_cfg_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              write,
  input  logic              Lock,
  output logic [DATA_W-1:0] rd_data
);

  logic              locked_reg;
  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      locked_reg <= 1'b0;
    end else if (Lock) begin
      locked_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
          regs_reg[gi] <= '0;
        end else if (write && !locked_reg && (reg_sel == SEL_W'(gi))) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_sel == SEL_W'(i)) rd_data = regs_reg[i];
    end
  end

endmodule

// File: rtl/lock_config_sequencer.sv
// Programs and verifies a bank of lockable registers, locks it, then proves the
// lock holds by attempting an inverted write to register 0.
module lock_config_sequencer
  import lock_cfg_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_REGS  = 4,
  parameter int MAX_RETRY = 2,
  parameter int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       Clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [NUM_REGS*DATA_W-1:0] cfg_data,
  output logic [SEL_W-1:0]           reg_sel,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       write,
  output logic                       Lock,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [SEL_W-1:0]           err_idx,
  output logic                       err_probe
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [SEL_W-1:0]   IDX_LAST   = SEL_W'(NUM_REGS - 1);

  lock_seq_state_t state_reg, state_next;
  logic [SEL_W-1:0]   idx_reg, idx_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [SEL_W-1:0]   err_idx_reg, err_idx_next;
  logic               err_probe_reg, err_probe_next;
  logic               start_accept;

  logic [DATA_W-1:0] words_reg  [NUM_REGS];
  logic [DATA_W-1:0] words_next [NUM_REGS];

  logic [SEL_W-1:0]  reg_sel_reg, reg_sel_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              write_reg, write_next;
  logic              lock_reg, lock_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;

  // The first WRITE must drive the freshly sampled word, so the data path
  // looks at the next-cycle copy of the configuration.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
      assign words_next[gi] = start_accept ? cfg_data[gi*DATA_W +: DATA_W] : words_reg[gi];

      always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
          words_reg[gi] <= '0;
        end else begin
          words_reg[gi] <= words_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    retry_next     = retry_reg;
    err_idx_next   = err_idx_reg;
    err_probe_next = err_probe_reg;
    start_accept   = 1'b0;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          start_accept   = 1'b1;
          idx_next       = '0;
          retry_next     = '0;
          err_idx_next   = '0;
          err_probe_next = 1'b0;
          state_next     = WRITE;
        end
      end
      WRITE: state_next = VERIFY;
      VERIFY: begin
        if (rd_data == words_reg[idx_reg]) begin
          if (idx_reg == IDX_LAST) begin
            state_next = LOCK;
          end else begin
            idx_next   = idx_reg + SEL_W'(1);
            retry_next = '0;
            state_next = WRITE;
          end
        end else if (retry_reg != RETRY_LAST) begin
          retry_next = retry_reg + RETRY_W'(1);
          state_next = WRITE;
        end else begin
          err_idx_next   = idx_reg;
          err_probe_next = ERR_VERIFY;
          state_next     = ERROR;
        end
      end
      LOCK:  state_next = PROBE;
      PROBE: state_next = CHECK;
      CHECK: begin
        if (rd_data == words_reg[0]) begin
          state_next = DONE;
        end else begin
          err_idx_next   = '0;
          err_probe_next = ERR_PROBE;
          state_next     = ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so the bank sees clean strobes.
  always_comb begin
    write_next   = (state_next == WRITE) || (state_next == PROBE);
    lock_next    = (state_next == LOCK);
    busy_next    = (state_next == WRITE) || (state_next == VERIFY) || (state_next == LOCK)
                || (state_next == PROBE) || (state_next == CHECK);
    done_next    = (state_next == DONE);
    error_next   = (state_next == ERROR);
    reg_sel_next = '0;
    wr_data_next = '0;
    if ((state_next == WRITE) || (state_next == VERIFY)) reg_sel_next = idx_next;
    if (state_next == WRITE) wr_data_next = words_next[idx_next];
    if (state_next == PROBE) wr_data_next = ~words_next[0];
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      retry_reg     <= '0;
      err_idx_reg   <= '0;
      err_probe_reg <= 1'b0;
      reg_sel_reg   <= '0;
      wr_data_reg   <= '0;
      write_reg     <= 1'b0;
      lock_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      retry_reg     <= retry_next;
      err_idx_reg   <= err_idx_next;
      err_probe_reg <= err_probe_next;
      reg_sel_reg   <= reg_sel_next;
      wr_data_reg   <= wr_data_next;
      write_reg     <= write_next;
      lock_reg      <= lock_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  assign reg_sel   = reg_sel_reg;
  assign wr_data   = wr_data_reg;
  assign write     = write_reg;
  assign Lock      = lock_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign err_idx   = err_idx_reg;
  assign err_probe = err_probe_reg;

endmodule

// File: tb/tb_lock_config_sequencer.sv
// Randomized bench: sequencer driving a real lockable bank, with optional stuck
// bit on reg 2 and a lock-ignoring bank, checked against a transaction model.
module tb_lock_config_sequencer;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 4;
  localparam int MAX_RETRY = 2;
  localparam int SEL_W     = 2;

  logic                       Clk;
  logic                       resetn;
  logic                       start;
  logic [NUM_REGS*DATA_W-1:0] cfg_data;
  logic [SEL_W-1:0]           reg_sel;
  logic [DATA_W-1:0]          wr_data;
  logic                       write;
  logic                       Lock;
  logic [DATA_W-1:0]          rd_data;
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [SEL_W-1:0]           err_idx;
  logic                       err_probe;

  logic [DATA_W-1:0] bank_rd;
  logic              bank_lock;
  logic              stuck_en;
  logic              broken_lock;

  assign bank_lock = Lock & ~broken_lock;
  assign rd_data   = (stuck_en && reg_sel == 2'd2) ? (bank_rd & 16'hFFFE) : bank_rd;

  lock_config_sequencer #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY), .SEL_W(SEL_W)
  ) dut (
    .Clk(Clk), .resetn(resetn), .start(start), .cfg_data(cfg_data),
    .reg_sel(reg_sel), .wr_data(wr_data), .write(write), .Lock(Lock),
    .rd_data(rd_data), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .err_probe(err_probe)
  );

  locked_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) bank (
    .Clk(Clk), .resetn(resetn), .reg_sel(reg_sel), .wr_data(wr_data),
    .write(write), .Lock(bank_lock), .rd_data(bank_rd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed strobes during a run
  logic                    mon_en = 1'b0;
  logic [SEL_W+DATA_W-1:0] obs_wr[$];
  int                      obs_lock = 0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (write) obs_wr.push_back({reg_sel, wr_data});
      if (Lock) obs_lock <= obs_lock + 1;
    end
  end

  // Reference model: bank contents and lock state as seen from outside
  logic [DATA_W-1:0]       words [NUM_REGS];
  logic [DATA_W-1:0]       mdl_content [NUM_REGS];
  bit                      mdl_locked;
  logic [SEL_W+DATA_W-1:0] exp_wr[$];
  int                      exp_lock, exp_edges;
  bit                      exp_done, exp_err, exp_probe;
  int                      exp_idx;

  function automatic logic [DATA_W-1:0] mdl_read(input int i);
    return mdl_content[i] & ((stuck_en && i == 2) ? 16'hFFFE : 16'hFFFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mdl_content[i] = '0;
    mdl_locked = 0;
  endtask

  task automatic model_run();
    int attempts;
    bit good;
    exp_wr.delete();
    exp_lock = 0; exp_done = 0; exp_err = 0; exp_idx = 0; exp_probe = 0;
    attempts = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      good = 0;
      for (int a = 0; a <= MAX_RETRY && !good; a++) begin
        exp_wr.push_back({SEL_W'(i), words[i]});
        attempts++;
        if (!mdl_locked) mdl_content[i] = words[i];
        good = (mdl_read(i) == words[i]);
      end
      if (!good) begin
        exp_err = 1; exp_idx = i; exp_edges = 2 * attempts;
        return;
      end
    end
    exp_lock = 1;
    if (!broken_lock) mdl_locked = 1;
    exp_wr.push_back({SEL_W'(0), ~words[0]});
    if (!mdl_locked) mdl_content[0] = ~words[0];
    exp_edges = 2 * attempts + 3;
    if (mdl_read(0) == words[0]) exp_done = 1;
    else begin exp_err = 1; exp_probe = 1; exp_idx = 0; end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] pack_words();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = words[i];
    return v;
  endfunction

  task automatic rand_words();
    for (int i = 0; i < NUM_REGS; i++) words[i] = DATA_W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge Clk) resetn = 1'b0;
    @(negedge Clk) resetn = 1'b1;
    model_reset();
  endtask

  task automatic run_seq(input string tag, input bit poke);
    int edges;
    model_run();
    obs_wr.delete();
    obs_lock = 0;
    @(negedge Clk);
    cfg_data = pack_words();
    start    = 1'b1;
    mon_en   = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    edges = 0;
    check_val({tag, "_busy_start"}, busy, 1);
    while (!(done || error) && edges < 100) begin
      @(posedge Clk); #1;
      edges++;
      if (poke && edges == 3) begin
        start    = 1'b1;
        cfg_data = {$urandom, $urandom};
      end else if (poke && edges == 4) begin
        start = 1'b0;
      end
    end
    start  = 1'b0;
    mon_en = 1'b0;
    $display("run %s: edges=%0d done=%0b error=%0b err_idx=%0d err_probe=%0b writes=%0d locks=%0d",
             tag, edges, done, error, err_idx, err_probe, obs_wr.size(), obs_lock);
    check_val({tag, "_edges"}, edges, exp_edges);
    check_val({tag, "_done"}, done, exp_done);
    check_val({tag, "_error"}, error, exp_err);
    check_val({tag, "_err_idx"}, err_idx, exp_idx);
    check_val({tag, "_err_probe"}, err_probe, exp_probe);
    check_val({tag, "_busy_end"}, busy, 0);
    check_val({tag, "_lock_cycles"}, obs_lock, exp_lock);
    check_val({tag, "_write_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check_val({tag, "_write_", $sformatf("%0d", i)}, obs_wr[i], exp_wr[i]);
  endtask

  // Start a run, drop resetn mid-cycle after n edges, check outputs fall at once.
  task automatic abort_run(input string tag, input int n);
    rand_words();
    @(negedge Clk);
    cfg_data = pack_words();
    start    = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (n) @(posedge Clk);
    #2;
    check_val({tag, "_pre_write"}, write, (n < 2 * NUM_REGS && n % 2 == 0) ? 1 : 0);
    check_val({tag, "_pre_lock"}, Lock, (n == 2 * NUM_REGS) ? 1 : 0);
    check_val({tag, "_pre_busy"}, busy, 1);
    resetn = 1'b0;
    #1;
    $display("abort %s: after %0d edges write=%0b Lock=%0b busy=%0b", tag, n, write, Lock, busy);
    check_val({tag, "_rst_write"}, write, 0);
    check_val({tag, "_rst_lock"}, Lock, 0);
    check_val({tag, "_rst_busy"}, busy, 0);
    check_val({tag, "_rst_done"}, done, 0);
    check_val({tag, "_rst_error"}, error, 0);
    check_val({tag, "_rst_sel"}, reg_sel, 0);
    @(negedge Clk) resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    cfg_data    = '0;
    stuck_en    = 1'b0;
    broken_lock = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_write", write, 0);
    check_val("rst_lock", Lock, 0);
    check_val("rst_sel", reg_sel, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_err_idx", err_idx, 0);
    check_val("rst_err_probe", err_probe, 0);
    @(negedge Clk) resetn = 1'b1;

    words[0] = 16'hA5A5; words[1] = 16'h3333; words[2] = 16'h2222; words[3] = 16'h1111;
    run_seq("nominal", 0);

    words[0] = 16'h0F0F; words[1] = 16'h1234; words[2] = 16'h5678; words[3] = 16'h9ABC;
    run_seq("rerun_locked", 0);

    do_reset();
    stuck_en = 1'b1;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h0003; words[3] = 16'h4444;
    run_seq("stuck_bit", 0);
    stuck_en = 1'b0;

    do_reset();
    broken_lock = 1'b1;
    words[0] = 16'hA5A5; words[1] = 16'h3333; words[2] = 16'h2222; words[3] = 16'h1111;
    run_seq("broken_lock", 0);
    broken_lock = 1'b0;

    do_reset();
    run_seq("busy_start", 1);

    abort_run("abort_verify1", 3);
    abort_run("abort_write1", 2);
    abort_run("abort_lock", 8);
    rand_words();
    run_seq("after_abort", 0);

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(1, 0) == 1) do_reset();
      stuck_en    = ($urandom_range(3, 0) == 0);
      broken_lock = ($urandom_range(3, 0) == 0);
      rand_words();
      if (stuck_en && $urandom_range(3, 0) != 0) words[2][0] = 1'b1;
      run_seq($sformatf("rand%0d", r), $urandom_range(1, 0) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
